// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: default reset PC, bubble encoding, FSM states, address helper.
package if_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush forces a bubble and has priority over load; otherwise holds.
// One-cycle latency from load/flush to outputs.
module if_fetch_stage_if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, req/ack imem FSM and IF/ID register. Ack with advance -> IF/ID next cycle.
// Stalls (pc_write/if_id_write_en/pstop) park an acked word in a one-entry buffer; requests are never withdrawn.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write_i,
    input  logic        if_id_write_en_i,
    input  logic        pstop_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_drop_addr, w_drop_addr_nxt;
    logic [31:0]  r_buf, w_buf_nxt;
    logic [31:0]  w_pc4, w_target, w_load_instr;
    logic         w_adv, w_br, w_load, w_flush;

    assign w_adv    = pc_write_i & if_id_write_en_i & ~pstop_i;
    // Redirects only need IF/ID to be writable; pc_write may be low for a load-use stall.
    assign w_br     = branch_taken_i & if_id_write_en_i & ~pstop_i;
    assign w_pc4    = r_pc + 32'd4;
    assign w_target = word_align(branch_target_i);

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_drop_addr_nxt = r_drop_addr;
        w_buf_nxt       = r_buf;
        w_load          = 1'b0;
        w_flush         = 1'b0;
        w_load_instr    = imem_rdata_i;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
                w_flush     = w_adv;
            end
            ST_FETCH: begin
                if (w_br) begin
                    w_pc_nxt = w_target;
                    w_flush  = 1'b1;
                    if (!imem_ack_i) begin
                        w_state_nxt     = ST_DROP;
                        w_drop_addr_nxt = r_pc;
                    end
                end else if (imem_ack_i && w_adv) begin
                    w_load   = 1'b1;
                    w_pc_nxt = w_pc4;
                end else if (imem_ack_i) begin
                    w_buf_nxt   = imem_rdata_i;
                    w_state_nxt = ST_HOLD;
                end else if (w_adv) begin
                    w_flush = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_br) begin
                    w_pc_nxt    = w_target;
                    w_flush     = 1'b1;
                    w_buf_nxt   = 32'h0;
                    w_state_nxt = ST_FETCH;
                end else if (w_adv) begin
                    w_load       = 1'b1;
                    w_load_instr = r_buf;
                    w_pc_nxt     = w_pc4;
                    w_buf_nxt    = 32'h0;
                    w_state_nxt  = ST_FETCH;
                end
            end
            ST_DROP: begin
                // The wrong-path request must still complete; its data is discarded.
                if (imem_ack_i) begin
                    w_state_nxt = ST_FETCH;
                end
                if (w_br) begin
                    w_pc_nxt = w_target;
                    w_flush  = 1'b1;
                end else if (w_adv) begin
                    w_flush = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= word_align(RESET_PC);
            r_drop_addr <= 32'h0;
            r_buf       <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop_addr <= w_drop_addr_nxt;
            r_buf       <= w_buf_nxt;
        end
    end

    assign imem_req_o  = (r_state == ST_FETCH) || (r_state == ST_DROP);
    assign imem_addr_o = (r_state == ST_DROP) ? r_drop_addr : r_pc;

    if_fetch_stage_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_instr (w_load_instr),
        .i_pc4   (w_pc4),
        .o_instr (if_id_instr_o),
        .o_pc4   (if_id_pc4_o),
        .o_valid (if_id_valid_o)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: inputs driven and outputs sampled just after the falling edge.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write_i;
    logic        if_id_write_en_i;
    logic        pstop_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    wire [32:0] obs_ra = {imem_req_o, imem_addr_o};
    wire [64:0] obs_id = {if_id_valid_o, if_id_pc4_o, if_id_instr_o};

    always #5 clk = ~clk;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_write_i       (pc_write_i),
        .if_id_write_en_i (if_id_write_en_i),
        .pstop_i          (pstop_i),
        .branch_taken_i   (branch_taken_i),
        .branch_target_i  (branch_target_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ack_i       (imem_ack_i),
        .imem_rdata_i     (imem_rdata_i),
        .if_id_instr_o    (if_id_instr_o),
        .if_id_pc4_o      (if_id_pc4_o),
        .if_id_valid_o    (if_id_valid_o)
    );

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (imem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b exp 0", imem_req_o);
        end
        n_chk++;
        if (obs_id !== {1'b0, 32'h0, NOP}) begin
            n_fail++; $display("FAIL reset_ifid: got %h exp %h", obs_id, {1'b0, 32'h0, NOP});
        end
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (imem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_req: got %b exp 0", imem_req_o);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_chk++;
            if (obs_ra !== {1'b1, 32'(i * 4)}) begin
                n_fail++; $display("FAIL seq_addr%0d: got %h exp %h", i, obs_ra, {1'b1, 32'(i * 4)});
            end
            if (i > 0) begin
                n_chk++;
                if (obs_id !== {1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i - 1)}) begin
                    n_fail++; $display("FAIL seq_ifid%0d: got %h exp %h", i, obs_id,
                                       {1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i - 1)});
                end
            end
            imem_ack_i   = 1'b1;
            imem_rdata_i = 32'h1000_0000 + 32'(i);
        end
    endtask

    task automatic test_latency();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_chk++;
            if (obs_ra !== {1'b1, 32'd12}) begin
                n_fail++; $display("FAIL lat_addr%0d: got %h exp %h", k, obs_ra, {1'b1, 32'd12});
            end
            n_chk++;
            if (k == 0) begin
                if (obs_id !== {1'b1, 32'd12, 32'h1000_0002}) begin
                    n_fail++; $display("FAIL lat_prev: got %h exp %h", obs_id, {1'b1, 32'd12, 32'h1000_0002});
                end
            end else if (if_id_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL lat_bubble%0d: got %b exp 0", k, if_id_valid_o);
            end
            imem_ack_i   = (k == 2);
            imem_rdata_i = 32'hAAAA_0003;
        end
        @(negedge clk); #1;
        n_chk++;
        if (obs_id !== {1'b1, 32'd16, 32'hAAAA_0003}) begin
            n_fail++; $display("FAIL lat_deliver: got %h exp %h", obs_id, {1'b1, 32'd16, 32'hAAAA_0003});
        end
        imem_ack_i = 1'b0;
    endtask

    task automatic test_hold();
        @(negedge clk); #1;
        n_chk++;
        if (obs_ra !== {1'b1, 32'd16}) begin
            n_fail++; $display("FAIL hold_addr0: got %h exp %h", obs_ra, {1'b1, 32'd16});
        end
        imem_ack_i = 1'b1; imem_rdata_i = 32'hB000_0000;
        @(negedge clk); #1;
        n_chk++;
        if (obs_id !== {1'b1, 32'd20, 32'hB000_0000}) begin
            n_fail++; $display("FAIL hold_pre: got %h exp %h", obs_id, {1'b1, 32'd20, 32'hB000_0000});
        end
        imem_ack_i = 1'b1; imem_rdata_i = 32'hB000_0001; if_id_write_en_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_chk++;
            if (imem_req_o !== 1'b0) begin
                n_fail++; $display("FAIL hold_req%0d: got %b exp 0", c, imem_req_o);
            end
            n_chk++;
            if (obs_id !== {1'b1, 32'd20, 32'hB000_0000}) begin
                n_fail++; $display("FAIL hold_frozen%0d: got %h exp %h", c, obs_id, {1'b1, 32'd20, 32'hB000_0000});
            end
            imem_ack_i = 1'b0; imem_rdata_i = 32'hDEAD_0000;
            if_id_write_en_i = (c == 1);
        end
        @(negedge clk); #1;
        n_chk++;
        if (obs_id !== {1'b1, 32'd24, 32'hB000_0001}) begin
            n_fail++; $display("FAIL hold_release: got %h exp %h", obs_id, {1'b1, 32'd24, 32'hB000_0001});
        end
        n_chk++;
        if (obs_ra !== {1'b1, 32'd24}) begin
            n_fail++; $display("FAIL hold_next_addr: got %h exp %h", obs_ra, {1'b1, 32'd24});
        end
    endtask

    task automatic test_branch_pending();
        @(negedge clk); #1;
        n_chk++;
        if (obs_ra !== {1'b1, 32'h18}) begin
            n_fail++; $display("FAIL br_addr0: got %h exp %h", obs_ra, {1'b1, 32'h18});
        end
        branch_taken_i = 1'b1; branch_target_i = 32'h40;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_chk++;
            if (obs_ra !== {1'b1, 32'h18}) begin
                n_fail++; $display("FAIL br_drop_addr%0d: got %h exp %h", c, obs_ra, {1'b1, 32'h18});
            end
            n_chk++;
            if (obs_id !== {1'b0, 32'h0, NOP}) begin
                n_fail++; $display("FAIL br_flush%0d: got %h exp %h", c, obs_id, {1'b0, 32'h0, NOP});
            end
            branch_taken_i = 1'b0;
            imem_ack_i = (c == 1); imem_rdata_i = 32'hDEAD_BEEF;
        end
        @(negedge clk); #1;
        n_chk++;
        if (obs_ra !== {1'b1, 32'h40}) begin
            n_fail++; $display("FAIL br_target_addr: got %h exp %h", obs_ra, {1'b1, 32'h40});
        end
        n_chk++;
        if (obs_id !== {1'b0, 32'h0, NOP}) begin
            n_fail++; $display("FAIL br_dropped_data: got %h exp %h", obs_id, {1'b0, 32'h0, NOP});
        end
        imem_ack_i = 1'b1; imem_rdata_i = 32'hC000_0000;
        @(negedge clk); #1;
        n_chk++;
        if (obs_id !== {1'b1, 32'h44, 32'hC000_0000}) begin
            n_fail++; $display("FAIL br_first_target: got %h exp %h", obs_id, {1'b1, 32'h44, 32'hC000_0000});
        end
        imem_ack_i = 1'b0;
    endtask

    task automatic test_pstop();
        @(negedge clk); #1;
        n_chk++;
        if (obs_ra !== {1'b1, 32'h44}) begin
            n_fail++; $display("FAIL ps_addr: got %h exp %h", obs_ra, {1'b1, 32'h44});
        end
        imem_ack_i = 1'b1; imem_rdata_i = 32'hD000_0000; pstop_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_chk++;
            if ({imem_req_o, if_id_valid_o} !== 2'b00) begin
                n_fail++; $display("FAIL ps_frozen%0d: got %b exp 00", c, {imem_req_o, if_id_valid_o});
            end
            imem_ack_i = 1'b0;
            pstop_i = (c == 0);
        end
        @(negedge clk); #1;
        n_chk++;
        if (obs_id !== {1'b1, 32'h48, 32'hD000_0000}) begin
            n_fail++; $display("FAIL ps_deliver: got %h exp %h", obs_id, {1'b1, 32'h48, 32'hD000_0000});
        end
        @(negedge clk); #1;
        n_chk++;
        if ({if_id_valid_o, obs_ra} !== {1'b0, 1'b1, 32'h48}) begin
            n_fail++; $display("FAIL ps_no_dup: got %h exp %h", {if_id_valid_o, obs_ra}, {1'b0, 1'b1, 32'h48});
        end
    endtask

    task automatic test_reset_mid_fetch();
        @(negedge clk); #1;
        imem_ack_i = 1'b1; imem_rdata_i = 32'hE000_0000;
        @(negedge clk); #1;
        n_chk++;
        if (obs_id !== {1'b1, 32'h4C, 32'hE000_0000}) begin
            n_fail++; $display("FAIL rst_pre: got %h exp %h", obs_id, {1'b1, 32'h4C, 32'hE000_0000});
        end
        imem_ack_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({imem_req_o, obs_id} !== {1'b0, 1'b0, 32'h0, NOP}) begin
            n_fail++; $display("FAIL rst_async: got %h exp %h", {imem_req_o, obs_id}, {1'b0, 1'b0, 32'h0, NOP});
        end
        @(negedge clk); #1;
        imem_ack_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_chk++;
        if ({obs_ra, if_id_valid_o} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL rst_late_ack: got %h exp %h", {obs_ra, if_id_valid_o}, {1'b1, 32'h0, 1'b0});
        end
        imem_ack_i = 1'b1; imem_rdata_i = 32'hE000_0001;
        @(negedge clk); #1;
        n_chk++;
        if (obs_id !== {1'b1, 32'h4, 32'hE000_0001}) begin
            n_fail++; $display("FAIL rst_restart: got %h exp %h", obs_id, {1'b1, 32'h4, 32'hE000_0001});
        end
        imem_ack_i = 1'b0;
    endtask

    task automatic test_wrap();
        @(negedge clk); #1;
        n_chk++;
        if (obs_ra !== {1'b1, 32'h4}) begin
            n_fail++; $display("FAIL wrap_start: got %h exp %h", obs_ra, {1'b1, 32'h4});
        end
        branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        branch_taken_i = 1'b0; imem_ack_i = 1'b1; imem_rdata_i = 32'hBAD1_BAD1;
        @(negedge clk); #1;
        n_chk++;
        if (obs_ra !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++; $display("FAIL wrap_trunc: got %h exp %h", obs_ra, {1'b1, 32'hFFFF_FFFC});
        end
        imem_ack_i = 1'b1; imem_rdata_i = 32'hF000_0000;
        @(negedge clk); #1;
        n_chk++;
        if (obs_id !== {1'b1, 32'h0, 32'hF000_0000}) begin
            n_fail++; $display("FAIL wrap_pc4: got %h exp %h", obs_id, {1'b1, 32'h0, 32'hF000_0000});
        end
        n_chk++;
        if (obs_ra !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL wrap_pc: got %h exp %h", obs_ra, {1'b1, 32'h0});
        end
        imem_ack_i = 1'b0;
    endtask

    task automatic test_branch_with_ack();
        @(negedge clk); #1;
        imem_ack_i = 1'b1; imem_rdata_i = 32'hBAD2_BAD2;
        branch_taken_i = 1'b1; branch_target_i = 32'h80; pc_write_i = 1'b0;
        @(negedge clk); #1;
        n_chk++;
        if (obs_ra !== {1'b1, 32'h80}) begin
            n_fail++; $display("FAIL brack_addr: got %h exp %h", obs_ra, {1'b1, 32'h80});
        end
        n_chk++;
        if (obs_id !== {1'b0, 32'h0, NOP}) begin
            n_fail++; $display("FAIL brack_flush: got %h exp %h", obs_id, {1'b0, 32'h0, NOP});
        end
        imem_ack_i = 1'b0; branch_taken_i = 1'b0; pc_write_i = 1'b1;
    endtask

    initial begin
        rst_n            = 1'b0;
        pc_write_i       = 1'b1;
        if_id_write_en_i = 1'b1;
        pstop_i          = 1'b0;
        branch_taken_i   = 1'b0;
        branch_target_i  = 32'h0;
        imem_ack_i       = 1'b0;
        imem_rdata_i     = 32'h0;
        test_reset();
        test_sequential();
        test_latency();
        test_hold();
        test_branch_pending();
        test_pstop();
        test_reset_mid_fetch();
        test_wrap();
        test_branch_with_ack();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
